// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two prioritised write ports, zero register, bypass and clear sequencer
// Ports: clk/rst (sync, active-high); rs/rdata packed read ports (combinational);
//        we0/wa0/wd0 and we1/wa1/wd1 write ports (port 1 wins on same address);
//        init_busy, wr_collision, addr_err registered status outputs.
module reg_file_mp #(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rs,
  output logic [NUM_RD*N-1:0]  rdata,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [N-1:0]         wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [N-1:0]         wd1,
  output logic                 init_busy,
  output logic                 wr_collision,
  output logic                 addr_err
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t        r_state, w_state_nxt;
  logic [AW:0]   r_cnt, w_cnt_nxt;
  logic [N-1:0]  r_mem [DEPTH];
  logic          r_init_busy, r_wr_collision, r_addr_err;
  logic          w_ready, w_in0, w_in1, w_ok0, w_ok1, w_coll, w_err;
  assign w_ready = r_state == READY;
  assign w_in0   = {1'b0, wa0} < (AW+1)'(DEPTH);
  assign w_in1   = {1'b0, wa1} < (AW+1)'(DEPTH);
  // ok = write actually lands in the array (ready, in range, not the zero register)
  assign w_ok0   = w_ready && we0 && w_in0 && !(ZERO_REG != 0 && wa0 == '0);
  assign w_ok1   = w_ready && we1 && w_in1 && !(ZERO_REG != 0 && wa1 == '0);
  // collision is flagged even when the shared address is the discarded zero register
  assign w_coll  = w_ready && we0 && we1 && w_in0 && wa0 == wa1;
  assign w_err   = w_ready && ((we0 && !w_in0) || (we1 && !w_in1));
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == CLEAR) begin
      w_cnt_nxt   = r_cnt + 1'b1;
      w_state_nxt = (r_cnt == (AW+1)'(DEPTH-1)) ? READY : CLEAR;
    end
  end
  always_ff @(posedge clk) begin
    r_state        <= rst ? CLEAR : w_state_nxt;
    r_cnt          <= rst ? '0 : w_cnt_nxt;
    r_init_busy    <= rst ? 1'b1 : (w_state_nxt == CLEAR);
    r_wr_collision <= rst ? 1'b0 : w_coll;
    r_addr_err     <= rst ? 1'b0 : w_err;
  end
  // contents are left alone on the reset edge; the sequencer clears them afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR) r_mem[r_cnt[AW-1:0]] <= '0;
      if (w_ok0 && !w_coll) r_mem[wa0] <= wd0;
      if (w_ok1) r_mem[wa1] <= wd1;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_zero;
    assign w_ra   = rs[i*AW +: AW];
    assign w_zero = !w_ready || {1'b0, w_ra} >= (AW+1)'(DEPTH) || (ZERO_REG != 0 && w_ra == '0);
    assign rdata[i*N +: N] = w_zero ? '0 :
                             (BYPASS != 0 && w_ok1 && wa1 == w_ra) ? wd1 :
                             (BYPASS != 0 && w_ok0 && wa0 == w_ra) ? wd0 :
                             r_mem[w_ra];
  end
  assign init_busy    = r_init_busy;
  assign wr_collision = r_wr_collision;
  assign addr_err     = r_addr_err;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: table-driven bench with flag scoreboard for two reg_file_mp configurations
module tb_reg_file_mp;
  logic        clk = 0;
  logic        rst;
  logic [9:0]  rs;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [63:0] rdata_a, rdata_b;
  logic        busy_a, busy_b, coll_a, coll_b, err_a, err_b;
  int          n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  reg_file_mp #(.N(32), .DEPTH(32), .AW(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rs(rs), .rdata(rdata_a), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .init_busy(busy_a), .wr_collision(coll_a), .addr_err(err_a));
  reg_file_mp #(.N(32), .DEPTH(24), .AW(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rs(rs), .rdata(rdata_b), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .init_busy(busy_b), .wr_collision(coll_b), .addr_err(err_b));
  typedef struct {
    logic we0; logic [4:0] wa0; logic [31:0] wd0;
    logic we1; logic [4:0] wa1; logic [31:0] wd1;
    logic [4:0] r0, r1;
    logic [31:0] ea0, ea1, eb0, eb1;
    logic ca, ea, cb, eb;
  } vec_t;
  typedef struct {logic ca, ea, cb, eb; int idx;} flg_t;
  vec_t v[17];
  flg_t sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic run_clear(output int na, output int nb);
    na = 0;
    nb = 0;
    @(negedge clk);
    rst = 0; we0 = 1; wa0 = 5; wd0 = 32'hFFFF_FFFF; we1 = 1; wa1 = 5; wd1 = 32'hEEEE_EEEE;
    rs = {5'd5, 5'd5};
    for (int k = 1; k <= 40 && na == 0; k++) begin
      @(posedge clk); #1;
      if (nb == 0) begin
        chk("clear_coll_b", coll_b, 0);
        chk("clear_err_b", err_b, 0);
        chk("clear_rd_b", rdata_b[31:0], 0);
        if (!busy_b) begin nb = k; we0 = 0; we1 = 0; end
      end
      if (busy_a) begin
        chk("clear_coll_a", coll_a, 0);
        chk("clear_rd_a", rdata_a[31:0], 0);
      end else na = k;
    end
    chk("busy_len_a", na, 32);
    chk("busy_len_b", nb, 24);
  endtask
  task automatic read_all_zero();
    @(negedge clk);
    we0 = 0; we1 = 0;
    for (int a = 0; a < 32; a += 2) begin
      rs = {5'(a + 1), 5'(a)};
      #1;
      chk($sformatf("zero_a0_%0d", a), rdata_a[31:0], 0);
      chk($sformatf("zero_a1_%0d", a + 1), rdata_a[63:32], 0);
      chk($sformatf("zero_b0_%0d", a), rdata_b[31:0], 0);
      chk($sformatf("zero_b1_%0d", a + 1), rdata_b[63:32], 0);
    end
  endtask
  initial begin
    int na, nb;
    flg_t f;
    v[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
    v[1]  = '{0, 0,  0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0};
    v[2]  = '{0, 0,  0, 1, 7, 32'h12345678, 7, 5, 32'h12345678, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0};
    v[3]  = '{0, 0,  0, 0, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 0, 0, 0, 0};
    v[4]  = '{1, 9,  32'hAAAA, 1, 9, 32'h5555, 9, 9, 32'h5555, 32'h5555, 0, 0, 1, 0, 1, 0};
    v[5]  = '{0, 0,  0, 0, 0, 0, 9, 9, 32'h5555, 32'h5555, 32'h5555, 32'h5555, 0, 0, 0, 0};
    v[6]  = '{1, 0,  32'hFFFF, 0, 0, 0, 0, 9, 0, 32'h5555, 0, 32'h5555, 0, 0, 0, 0};
    v[7]  = '{0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v[8]  = '{1, 30, 32'hCAFE, 0, 0, 0, 30, 30, 32'hCAFE, 32'hCAFE, 0, 0, 0, 0, 0, 1};
    v[9]  = '{0, 0,  0, 0, 0, 0, 30, 23, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0};
    v[10] = '{1, 25, 32'h1111, 1, 26, 32'h2222, 25, 26, 32'h1111, 32'h2222, 0, 0, 0, 0, 0, 1};
    v[11] = '{0, 0,  0, 0, 0, 0, 25, 26, 32'h1111, 32'h2222, 0, 0, 0, 0, 0, 0};
    v[12] = '{1, 3,  32'h33, 1, 4, 32'h44, 3, 4, 32'h33, 32'h44, 0, 0, 0, 0, 0, 0};
    v[13] = '{0, 0,  0, 0, 0, 0, 3, 4, 32'h33, 32'h44, 32'h33, 32'h44, 0, 0, 0, 0};
    v[14] = '{1, 0,  32'h1, 1, 0, 32'h2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    v[15] = '{1, 28, 32'h77, 1, 28, 32'h88, 28, 28, 32'h88, 32'h88, 0, 0, 1, 0, 0, 1};
    v[16] = '{0, 0,  0, 0, 0, 0, 28, 5, 32'h88, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0, 0};
    rst = 1; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rs = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_a", busy_a, 1);
    chk("rst_busy_b", busy_b, 1);
    chk("rst_coll_a", coll_a, 0);
    chk("rst_err_b", err_b, 0);
    run_clear(na, nb);
    read_all_zero();
    foreach (v[i]) begin
      @(negedge clk);
      we0 = v[i].we0; wa0 = v[i].wa0; wd0 = v[i].wd0;
      we1 = v[i].we1; wa1 = v[i].wa1; wd1 = v[i].wd1;
      rs = {v[i].r1, v[i].r0};
      #2;
      chk($sformatf("v%0d_a0", i), rdata_a[31:0], v[i].ea0);
      chk($sformatf("v%0d_a1", i), rdata_a[63:32], v[i].ea1);
      chk($sformatf("v%0d_b0", i), rdata_b[31:0], v[i].eb0);
      chk($sformatf("v%0d_b1", i), rdata_b[63:32], v[i].eb1);
      sb.push_back('{v[i].ca, v[i].ea, v[i].cb, v[i].eb, i});
      @(posedge clk); #1;
      f = sb.pop_front();
      chk($sformatf("v%0d_coll_a", f.idx), coll_a, f.ca);
      chk($sformatf("v%0d_err_a", f.idx), err_a, f.ea);
      chk($sformatf("v%0d_coll_b", f.idx), coll_b, f.cb);
      chk($sformatf("v%0d_err_b", f.idx), err_b, f.eb);
    end
    @(negedge clk);
    we0 = 0; we1 = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy_a", busy_a, 1);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_busy_a", busy_a, 1);
    chk("mid_rst_busy_b", busy_b, 1);
    run_clear(na, nb);
    read_all_zero();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the pipelined processor datapath. It succeeds the single-write, two-read register file and adds the following:
- configurable read-port count
- two synchronous write ports with defined priority
- a hardwired zero register
- optional write-to-read bypass
- a self-clearing initialisation sequencer started by reset
The decode stage reads it; the writeback stage(s) write it.

Parameters:
N, 32, data width in bits
DEPTH, 32, number of registers (need not be a power of 2)
AW, 5, address width; must satisfy 2**AW >= DEPTH
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes
BYPASS, 1, when 1, same-cycle write data is forwarded to matching reads

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
rs  input  NUM_RD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rdata  output  NUM_RD*N  packed read data; port i uses bits [i*N +: N]; combinational
we0  input  1  write enable, port 0
wa0  input  AW  write address, port 0
wd0  input  N  write data, port 0
we1  input  1  write enable, port 1 (priority port)
wa1  input  AW  write address, port 1
wd1  input  N  write data, port 1
init_busy  output  1  high while the clear sequence runs; registered
wr_collision  output  1  one-cycle pulse: both ports wrote the same address last cycle; registered
addr_err  output  1  one-cycle pulse: an enabled write targeted address >= DEPTH last cycle; registered

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, named rst.
- FSM has two states, CLEAR and READY.
- Reset (any rising edge of clk with rst=1):
  - state<=CLEAR, clear counter cnt<=0
  - init_busy<=1, wr_collision<=0, addr_err<=0
  - Register contents are not touched on the reset edge itself.
- CLEAR state, each edge with rst=0:
  - mem[cnt]<=0 and cnt<=cnt+1.
  - On the edge that clears DEPTH-1: state<=READY, init_busy<=0.
  - init_busy therefore falls exactly DEPTH edges after the last reset edge.
- rst reasserted during CLEAR restarts the sequence at cnt=0.
- In CLEAR:
  - we0/we1 are ignored; no write, no collision, no error flags.
  - All rdata ports drive 0.
- READY, write rules:
  - An enabled write with address < DEPTH updates mem on the rising edge.
  - Writes to address 0 are discarded when ZERO_REG=1.
  - Both ports may write different addresses in the same cycle; both take effect.
  - we0=we1=1 with wa0==wa1 (valid address): wd1 is stored and wr_collision pulses high the next cycle. This holds even for address 0 under ZERO_REG (still flagged, nothing stored).
  - An enabled write with address >= DEPTH writes nothing; addr_err pulses high for one cycle. Either or both ports can trigger it.
- READY, read rules (combinational, per port independently):
  - Address >= DEPTH returns 0.
  - Address 0 with ZERO_REG=1 returns 0.
  - Otherwise, if BYPASS=1 and a same-cycle enabled, non-discarded write matches the address, return the write data; port 1 wins if both match.
  - Otherwise return mem[addr].
  - With BYPASS=0, the new value is visible from the cycle after the write edge.
- wr_collision and addr_err are recomputed every edge, so they are high for exactly one cycle per offending cycle.
- No arithmetic on data; widths pass through unchanged.
- cnt is AW+1 bits wide so the end-of-clear compare cannot wrap.

Test Plan:
- Reset and clear, DEPTH=32: assert rst 2 cycles, release. Required: init_busy=1 for exactly 32 edges, then 0; every register reads 0; writes issued during CLEAR have no effect.
- Basic write/read, READY, BYPASS=0: we0=1, wa0=5, wd0=0xDEADBEEF. Required: rs port0=5 reads the old value (0) in that cycle and 0xDEADBEEF the next cycle; rs port1=5 agrees.
- Bypass, BYPASS=1: we1=1, wa1=7, wd1=0x12345678 with rs port0=7 in the same cycle. Required: rdata port0=0x12345678 combinationally; after the edge, mem[7]=0x12345678.
- Collision and zero register: we0=we1=1, wa0=wa1=9, wd0=0xAAAA, wd1=0x5555. Required: reg 9 reads 0x5555 and wr_collision=1 for one cycle. Then we0=1, wa0=0, wd0=0xFFFF: reg 0 still reads 0, wr_collision=0.
- Out-of-range, DEPTH=24, AW=5: we0=1, wa0=30. Required: addr_err=1 for one cycle, no register changes, rs=30 reads 0.
- Reset mid-clear: assert rst at cnt=10 of CLEAR. Required: sequence restarts; init_busy stays high until 32 (DEPTH) edges after the rst release.
